adc_therm_capture: RTL and testbench

- Upstream front end of the flash-ADC thermometer-to-binary decoder.
- Takes the raw, asynchronous comparator outputs and synchronises them into clk.
- On a programmable sample strobe it applies 3-input majority bubble correction and presents a registered 15-bit thermometer word with a valid/ready handshake.
- Downstream, the thermometer-to-binary decoder consumes ith; that decoder maps any non-thermometer word to 0, which is why this block flags residual errors.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_bubble_fix.sv | 35 +++
 rtl/sync_ff.sv | 30 +++
 rtl/adc_therm_capture.sv | 131 +++++++++++++
 tb/tb_adc_therm_capture.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the flash-ADC thermometer front end.
// Holds the comparator count, the binary code width and the thermometer word type.
// therm_is_legal() accepts only words of the form 0..01..1, including all-zeros and all-ones.
package adc_pkg;

  localparam int ADC_N_CMP = 15;
  localparam int ADC_BIN_W = 4;

  typedef logic [ADC_N_CMP-1:0] therm_t;

  // A legal thermometer word is a run of ones starting at bit0. Adding one to
  // such a word yields a single set bit with no overlap. The extra MSB lets the
  // all-ones word carry out cleanly.
  function automatic logic therm_is_legal(input therm_t c);
    logic [ADC_N_CMP:0] w;
    w = {1'b0, c};
    return ((w & (w + (ADC_N_CMP+1)'(1))) == '0);
  endfunction

endpackage

// File: rtl/adc_bubble_fix.sv
// 3-input majority bubble correction followed by a thermometer legality check.
// Latency: purely combinational.
// Backpressure: none.
// Ports: s (synchronised comparator word), c (corrected word), legal (c is a thermometer code).
module adc_bubble_fix
  import adc_pkg::*;
#(
  parameter int N_CMP = ADC_N_CMP
) (
  input  logic [N_CMP-1:0] s,
  output logic [N_CMP-1:0] c,
  output logic             legal
);

  // Pad below bit0 with a one and above the top bit with a zero. Then the edge
  // comparators vote against the value that a perfect ladder would show there.
  logic [N_CMP+1:0] ext;

  always_comb begin
    ext = {1'b0, s, 1'b1};
    c   = '0;
    for (int i = 0; i < N_CMP; i++) begin
      c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  if (N_CMP == ADC_N_CMP) begin : g_pkg_legal
    assign legal = therm_is_legal(c);
  end else begin : g_gen_legal
    logic [N_CMP:0] w;
    assign w     = {1'b0, c};
    assign legal = ((w & (w + (N_CMP+1)'(1))) == '0);
  end

endmodule

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for asynchronous inputs, one chain per bit.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; it samples every cycle.
// Ports: clk, rst (sync, active-high, clears all stages), d (async in), q (synchronised out).
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  // Stage 0 takes the raw input; each later stage takes the one before it.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adc_therm_capture.sv
// Synchronises raw comparators, bubble-corrects them on a divided strobe and registers the thermometer word.
// Latency: s is sampled on the strobe cycle and ith_valid rises on the next clk edge; cmp_in to ith is SYNC_STAGES+1.
// Backpressure: a strobe that arrives while ith is held unaccepted is dropped and counted in overrun_cnt.
// Ports: clk, rst (sync, active-high), en, cnt_clr, cmp_in (async), ith/ith_valid/ith_ready (handshake),
//        code_err (qualifies ith), overrun_cnt, and bubble_cnt when ADC_THERM_BUBBLE_CNT_EN is defined.
module adc_therm_capture
  import adc_pkg::*;
#(
  parameter int N_CMP       = ADC_N_CMP,
  parameter int SAMPLE_DIV  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cnt_clr,
  input  logic [N_CMP-1:0] cmp_in,
  output logic [N_CMP-1:0] ith,
  output logic             ith_valid,
  input  logic             ith_ready,
  output logic             code_err,
`ifdef ADC_THERM_BUBBLE_CNT_EN
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [N_CMP-1:0] s;
  logic [N_CMP-1:0] c;
  logic             legal;

  sync_ff #(
    .WIDTH (N_CMP),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (cmp_in),
    .q  (s)
  );

  adc_bubble_fix #(
    .N_CMP(N_CMP)
  ) u_fix (
    .s    (s),
    .c    (c),
    .legal(legal)
  );

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [N_CMP-1:0] ith_q, ith_d;
  logic             ith_valid_q, ith_valid_d;
  logic             code_err_q, code_err_d;
  logic [CNT_W-1:0] overrun_q, overrun_d;
  logic             strobe;
  logic             load;
  logic             drop;

  assign strobe = en & (cnt_q == DIV_W'(SAMPLE_DIV - 1));
  // Loading is allowed when the slot is empty or being emptied this same cycle.
  // That gives back-to-back delivery with no bubble.
  assign load   = strobe & (~ith_valid_q | ith_ready);
  assign drop   = strobe & ~load;

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!en || strobe) cnt_d = '0;
  end

  always_comb begin
    ith_d       = ith_q;
    code_err_d  = code_err_q;
    ith_valid_d = ith_valid_q;
    if (load) begin
      ith_d       = c;
      code_err_d  = ~legal;
      ith_valid_d = 1'b1;
    end else if (!strobe && ith_valid_q && ith_ready) begin
      ith_valid_d = 1'b0;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (cnt_clr)                 overrun_d = '0;
    else if (drop && !(&overrun_q)) overrun_d = overrun_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ith_q       <= '0;
      ith_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      overrun_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ith_q       <= ith_d;
      ith_valid_q <= ith_valid_d;
      code_err_q  <= code_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ith         = ith_q;
  assign ith_valid   = ith_valid_q;
  assign code_err    = code_err_q;
  assign overrun_cnt = overrun_q;

`ifdef ADC_THERM_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Counts accepted samples where the majority vote changed at least one bit.
  always_comb begin
    bubble_d = bubble_q;
    if (cnt_clr)                                  bubble_d = '0;
    else if (load && (c != s) && !(&bubble_q))    bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else     bubble_q <= bubble_d;
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_adc_therm_capture.sv
// Directed bench for adc_therm_capture: one instance at SAMPLE_DIV=4 and one at SAMPLE_DIV=1.
// Inputs are driven and outputs sampled on the falling edge; design state changes on the rising edge.
// Define ADC_THERM_BUBBLE_CNT_EN to also exercise bubble_cnt.
module tb_adc_therm_capture;

  logic        clk;
  logic        rst;

  logic        en, cnt_clr, ith_ready;
  logic [14:0] cmp_in;
  logic [14:0] ith;
  logic        ith_valid, code_err;
  logic [7:0]  overrun_cnt;

  logic        en1, cnt_clr1, ith_ready1;
  logic [14:0] cmp_in1;
  logic [14:0] ith1;
  logic        ith_valid1, code_err1;
  logic [7:0]  overrun_cnt1;

`ifdef ADC_THERM_BUBBLE_CNT_EN
  logic [7:0]  bubble_cnt, bubble_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  adc_therm_capture #(.SAMPLE_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr), .cmp_in(cmp_in),
    .ith(ith), .ith_valid(ith_valid), .ith_ready(ith_ready), .code_err(code_err),
`ifdef ADC_THERM_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .overrun_cnt(overrun_cnt)
  );

  adc_therm_capture #(.SAMPLE_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .cnt_clr(cnt_clr1), .cmp_in(cmp_in1),
    .ith(ith1), .ith_valid(ith_valid1), .ith_ready(ith_ready1), .code_err(code_err1),
`ifdef ADC_THERM_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt1),
`endif
    .overrun_cnt(overrun_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bounded wait for ith_valid on the divided instance; a timeout counts as a failure.
  task automatic wait_vld(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ith_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: ith_valid timeout, got %b want 1", name, ith_valid);
    end
  endtask

  // Hold cmp_in long enough that every recent strobe saw it, then find a valid word.
  task automatic capture(input logic [14:0] v, input string name, output bit ok);
    cmp_in = v;
    repeat (8) @(negedge clk);
    wait_vld(name, ok);
  endtask

  // Empty the output slot and park the divider at 0 so the next load is predictable.
  task automatic drain_park;
    en = 1'b0; ith_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (ith !== 15'h0)      begin fails++; $display("FAIL reset_ith: got %h want 0000", ith); end
    tests++; if (ith_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ith_valid); end
    tests++; if (code_err !== 1'b0)  begin fails++; $display("FAIL reset_code_err: got %b want 0", code_err); end
    tests++; if (overrun_cnt !== 8'd0) begin fails++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
`ifdef ADC_THERM_BUBBLE_CNT_EN
    tests++; if (bubble_cnt !== 8'd0) begin fails++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single_bubble;
    bit ok;
    logic [7:0] b0;
    capture(15'b000000000001011, "single_bubble", ok);
    if (ok) begin
      tests++; if (ith !== 15'b000000000000111) begin fails++; $display("FAIL single_bubble_ith: got %b want 000000000000111", ith); end
      tests++; if (code_err !== 1'b0) begin fails++; $display("FAIL single_bubble_err: got %b want 0", code_err); end
`ifdef ADC_THERM_BUBBLE_CNT_EN
      b0 = bubble_cnt;
      @(negedge clk);
      wait_vld("single_bubble_next", ok);
      if (ok) begin
        tests++; if (bubble_cnt !== b0 + 8'd1) begin fails++; $display("FAIL bubble_cnt_step: got %0d want %0d", bubble_cnt, b0 + 8'd1); end
      end
`else
      b0 = 8'd0;
`endif
    end
  endtask

  task automatic test_patterns;
    bit ok;
    capture(15'b100000000000000, "top_bit", ok);
    if (ok) begin
      tests++; if (ith !== 15'h0 || code_err !== 1'b0) begin fails++; $display("FAIL top_bit: got ith=%b err=%b want ith=0 err=0", ith, code_err); end
    end
    capture(15'h7fff, "all_ones", ok);
    if (ok) begin
      tests++; if (ith !== 15'h7fff || code_err !== 1'b0) begin fails++; $display("FAIL all_ones: got ith=%b err=%b want ith=7fff err=0", ith, code_err); end
    end
    capture(15'h0, "all_zeros", ok);
    if (ok) begin
      tests++; if (ith !== 15'h0 || code_err !== 1'b0) begin fails++; $display("FAIL all_zeros: got ith=%b err=%b want ith=0 err=0", ith, code_err); end
    end
  endtask

  task automatic test_double_bubble;
    bit ok;
    capture(15'b000000000110011, "double_bubble", ok);
    if (ok) begin
      tests++; if (ith !== 15'b000000000110011) begin fails++; $display("FAIL double_bubble_ith: got %b want 000000000110011", ith); end
      tests++; if (code_err !== 1'b1) begin fails++; $display("FAIL double_bubble_err: got %b want 1", code_err); end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    cmp_in = 15'h0007;
    drain_park;
    ith_ready = 1'b0; en = 1'b1;
    wait_vld("bp_first", ok);
    if (ok) begin
      tests++; if (ith !== 15'h0007) begin fails++; $display("FAIL bp_first_ith: got %h want 0007", ith); end
      cmp_in = 15'h001f;
      // Two more strobes arrive while the slot is full.
      repeat (8) @(negedge clk);
      tests++; if (ith !== 15'h0007 || ith_valid !== 1'b1) begin fails++; $display("FAIL bp_frozen: got ith=%h vld=%b want ith=0007 vld=1", ith, ith_valid); end
      tests++; if (overrun_cnt !== 8'd2) begin fails++; $display("FAIL bp_overrun: got %0d want 2", overrun_cnt); end
      // Accept during the next strobe cycle: the new word loads with no gap.
      repeat (3) @(negedge clk);
      ith_ready = 1'b1;
      @(negedge clk);
      tests++; if (ith !== 15'h001f || ith_valid !== 1'b1) begin fails++; $display("FAIL bp_b2b: got ith=%h vld=%b want ith=001f vld=1", ith, ith_valid); end
      tests++; if (overrun_cnt !== 8'd2) begin fails++; $display("FAIL bp_overrun_hold: got %0d want 2", overrun_cnt); end
    end
  endtask

  task automatic test_cadence;
    logic [14:0] seq [5];
    seq[0] = 15'h0001; seq[1] = 15'h0003; seq[2] = 15'h0007; seq[3] = 15'h000f; seq[4] = 15'h001f;
    cmp_in1 = 15'h0; en1 = 1'b1; ith_ready1 = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        tests++; if (ith1 !== 15'h0) begin fails++; $display("FAIL cadence_early: got %h want 0000", ith1); end
      end
      if (k >= 3) begin
        tests++;
        if (ith1 !== seq[k-3] || ith_valid1 !== 1'b1) begin
          fails++; $display("FAIL cadence_%0d: got ith=%h vld=%b want ith=%h vld=1", k, ith1, ith_valid1, seq[k-3]);
        end
      end
      if (k < 5) cmp_in1 = seq[k];
      @(negedge clk);
    end
    en1 = 1'b0;
    @(negedge clk);
    tests++; if (ith_valid1 !== 1'b0) begin fails++; $display("FAIL cadence_drain: got %b want 0", ith_valid1); end
    cmp_in1 = 15'h00ff;
    repeat (4) @(negedge clk);
    tests++; if (ith_valid1 !== 1'b0 || ith1 !== 15'h001f) begin fails++; $display("FAIL cadence_noload: got ith=%h vld=%b want ith=001f vld=0", ith1, ith_valid1); end
  endtask

  task automatic test_enable;
    ith_ready1 = 1'b0; en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (ith_valid1 !== 1'b1 || ith1 !== 15'h00ff) begin fails++; $display("FAIL en_pending: got ith=%h vld=%b want ith=00ff vld=1", ith1, ith_valid1); end
    ith_ready1 = 1'b1;
    @(negedge clk);
    tests++; if (ith_valid1 !== 1'b0) begin fails++; $display("FAIL en_drain: got %b want 0", ith_valid1); end
  endtask

  task automatic test_saturation;
    ith_ready1 = 1'b0; en1 = 1'b1; cnt_clr1 = 1'b0;
    repeat (300) @(negedge clk);
    tests++; if (overrun_cnt1 !== 8'd255) begin fails++; $display("FAIL sat_overrun: got %0d want 255", overrun_cnt1); end
    cnt_clr1 = 1'b1;
    @(negedge clk);
    tests++; if (overrun_cnt1 !== 8'd0) begin fails++; $display("FAIL clr_wins: got %0d want 0", overrun_cnt1); end
    cnt_clr1 = 1'b0;
    @(negedge clk);
    tests++; if (overrun_cnt1 !== 8'd1) begin fails++; $display("FAIL clr_resume: got %0d want 1", overrun_cnt1); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    cmp_in = 15'h0003;
    drain_park;
    ith_ready = 1'b0; en = 1'b1;
    wait_vld("rst_mid_load", ok);
    if (ok) begin
      rst = 1'b1;
      @(negedge clk);
      tests++; if (ith_valid !== 1'b0 || ith !== 15'h0) begin fails++; $display("FAIL rst_mid: got ith=%h vld=%b want ith=0000 vld=0", ith, ith_valid); end
      tests++; if (overrun_cnt !== 8'd0) begin fails++; $display("FAIL rst_mid_overrun: got %0d want 0", overrun_cnt); end
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; cnt_clr = 1'b0; ith_ready = 1'b1; cmp_in = 15'h0;
    en1 = 1'b0; cnt_clr1 = 1'b0; ith_ready1 = 1'b1; cmp_in1 = 15'h0;
    @(negedge clk);
    test_reset;
    en = 1'b1;
    test_single_bubble;
    test_patterns;
    test_double_bubble;
    test_backpressure;
    test_cadence;
    test_enable;
    test_saturation;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
